icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch stage and the memory controller. It serves `imemaddr`/`imemREN` requests from the datapath, returning `imemload` with `ihit` on a hit. On a miss it fetches one word from memory over the `iREN`/`iwait` handshake, installs it, and then hits. It feeds the IF/ID pipeline register directly; the PC and IF/ID only advance on `ihit`.

## Interface
- `SETS`, 16 — number of lines. Power of two, 2..256. `IDX = log2(SETS)`, `TAGW = 30 - IDX`.
- `CLK` input 1 — system clock; all state updates on the rising edge.
- `nRST` input 1 — asynchronous, active-low reset.
- `imemREN` input 1 — datapath fetch request.
- `imemaddr` input 32 — fetch byte address; `[1:0]` ignored.
- `iflush` input 1 — invalidate all lines.
- `ihit` output 1 — `imemload` is valid for `imemaddr` this cycle.
- `imemload` output 32 — instruction word.
- `iREN` output 1 — memory read request.
- `iaddr` output 32 — memory read address, word-aligned (`[1:0]` = 0).
- `iload` input 32 — memory read data, valid when `iwait` = 0.
- `iwait` input 1 — memory busy; 0 while `iREN` = 1 means `iload` is valid this cycle.

## Operation
- Address split:
  - tag = `imemaddr[31:IDX+2]`
  - index = `imemaddr[IDX+1:2]`
- Per-line storage: `valid` (1 bit), `tag` (TAGW bits), `data` (32 bits).
- FSM states: IDLE and FILL. `miss_addr` is a 30-bit register holding the word address latched at the miss.
- IDLE behaviour:
  - `ihit = imemREN & valid[index] & (tag[index] == tag) & !iflush`.
  - `imemload = data[index]` when `ihit`, else 0.
  - `iREN` = 0 and `iaddr` = 0.
- IDLE → FILL: when `imemREN` is high, `ihit` is low, and `iflush` is low. Capture `miss_addr <= imemaddr[31:2]`.
- FILL behaviour:
  - `ihit` = 0 and `imemload` = 0.
  - `iREN` = 1 and `iaddr = {miss_addr, 2'b00}`.
  - `imemaddr` and `imemREN` are ignored. A fill runs to completion even if `imemREN` drops or the address changes.
- FILL → IDLE: on the edge where `iwait` = 0. Write the line at `miss_addr`'s index: `valid` = 1, tag from `miss_addr`, `data = iload`.
- FILL holds while `iwait` = 1; there is no timeout.
- `iflush` priority:
  - `iflush` beats both hit and fill.
  - On the edge where `iflush` = 1, all `valid` bits clear.
  - If the state is FILL, it aborts to IDLE with no line write, even if `iwait` = 0 that cycle.
- Conflict miss: a fill overwrites the existing line at that index unconditionally.
- Reset:
  - All `valid` = 0, state = IDLE, `miss_addr` = 0.
  - `tag` and `data` arrays need no reset.
  - Outputs after reset: `ihit` = 0, `imemload` = 0, `iREN` = 0, `iaddr` = 0.
  - Reset asserted mid-fill drops `iREN` immediately (asynchronously).

## Timing
- Hit path: `ihit` and `imemload` are combinational from `imemaddr`, `imemREN`, `iflush` and the array contents in the same cycle. Hit latency is 0 cycles.
- Miss latency, cycle by cycle:
  - Cycle 0: miss detected in IDLE.
  - Cycle 1: FILL, `iREN` = 1.
  - If `iwait` = 0 in cycle 1, the line is written at the end of cycle 1.
  - Cycle 2: IDLE, `ihit` = 1 if the same address is still presented.
  - Minimum miss-to-hit is 2 cycles; each extra `iwait` cycle adds 1.
- `iREN` and `iaddr` are decoded from registered state (glitch-free, FSM outputs only).
- `ihit` never asserts while in FILL, including the completion cycle.
- Back-to-back misses: after a fill, a new address that misses re-enters FILL one cycle later. There is at least one IDLE cycle between fills.
- `iflush` and `imemREN` in the same IDLE cycle: `ihit` = 0, no fill starts, and the request is re-evaluated next cycle against the empty cache.

## Test plan
- **Cold miss then hit.** Reset, then `imemREN` = 1 and `imemaddr` = 0x00000040 with memory returning `iwait` = 0 at once and `iload` = 0x2108000A.
  - Cycle 1: `iREN` = 1, `iaddr` = 0x40.
  - Cycle 2: `ihit` = 1, `imemload` = 0x2108000A.
- **Wait states.** Same fill with `iwait` held at 1 for 3 cycles.
  - `iREN` stays high for 4 cycles with `iaddr` stable.
  - `ihit` first asserts in cycle 5.
- **Conflict eviction.** SETS = 16. Fill 0x00000004 (data 0xAAAAAAAA), then 0x00000044 (same index 1, data 0xBBBBBBBB).
  - Re-reading 0x04 misses, with `iaddr` = 0x04.
  - 0x44 hits, returning 0xBBBBBBBB.
- **Address change mid-fill.** Miss on 0x100, then change `imemaddr` to 0x200 during FILL.
  - `iaddr` stays 0x100 and the fill installs 0x100.
  - The next IDLE cycle misses on 0x200.
- **Flush.** Fill 0x40, assert `iflush` for 1 cycle, then read 0x40: a miss with `iREN` = 1.
  - Assert `iflush` during FILL in a cycle where `iwait` = 0: no install, and the state returns to IDLE.
- **Reset mid-fill.** Drop `nRST` while in FILL.
  - `iREN` = 0 immediately.
  - After release, a read of the previously filled address misses.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache between fetch and memory.
// Hits are combinational from the request and array contents. A miss fetches
// one word over the iREN/iwait handshake, installs it, and hits afterwards.
//
//   state | meaning
//   IDLE  | serve lookups; a clean miss latches its word address and starts a fill
//   FILL  | iREN held with the latched address until iwait drops or iflush aborts
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 30 - IDX;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [29:0]     miss_addr_q, miss_addr_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [TAGW-1:0] req_tag;
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] fill_tag;
  logic [IDX-1:0]  fill_idx;
  logic            lookup_hit;
  logic            fill_done;
  logic            unused_byte_offset;

  assign req_tag  = imemaddr[31:IDX+2];
  assign req_idx  = imemaddr[IDX+1:2];
  assign fill_tag = miss_addr_q[29:IDX];
  assign fill_idx = miss_addr_q[IDX-1:0];

  // Byte offset within the word is irrelevant to a word-wide fetch.
  assign unused_byte_offset = ^imemaddr[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A flush in the completion cycle aborts the fill without installing.
  assign fill_done = (state_q == FILL) && !iwait && !iflush;

  // Output decode: hit path is combinational in IDLE, memory port is FSM-only.
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    if (state_q == IDLE) begin
      ihit = imemREN && lookup_hit && !iflush;
      if (ihit) begin
        imemload = data_q[req_idx];
      end
    end else begin
      iREN  = 1'b1;
      iaddr = {miss_addr_q, 2'b00};
    end
  end

  // Next-state logic for the FSM, the latched miss address and the valid bits.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !iflush && !lookup_hit) begin
          state_d     = FILL;
          miss_addr_d = imemaddr[31:2];
        end
      end
      FILL: begin
        if (iflush || !iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (iflush) begin
      valid_d = '0;
    end else if (fill_done) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  // Control state; reset also removes iREN asynchronously via state_q.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= 30'h0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays are guarded by valid bits, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed test of icache (SETS = 16) with hand-computed expectations.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  int vectors;
  int miscompares;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Full miss-fill-hit sequence with immediate memory response.
  task automatic do_fill(input string tag, input logic [31:0] addr, input logic [31:0] data);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b0;
    iload    = data;
    #1;
    chk({tag, " c0 ihit"}, {31'h0, ihit}, 32'h0);
    chk({tag, " c0 iREN"}, {31'h0, iREN}, 32'h0);
    next_cycle();
    #1;
    chk({tag, " c1 iREN"}, {31'h0, iREN}, 32'h1);
    chk({tag, " c1 iaddr"}, iaddr, addr);
    chk({tag, " c1 ihit"}, {31'h0, ihit}, 32'h0);
    next_cycle();
    #1;
    chk({tag, " c2 ihit"}, {31'h0, ihit}, 32'h1);
    chk({tag, " c2 imemload"}, imemload, data);
    chk({tag, " c2 iREN"}, {31'h0, iREN}, 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iflush   = 1'b0;
    iload    = 32'h0;
    iwait    = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    chk("rst ihit", {31'h0, ihit}, 32'h0);
    chk("rst imemload", imemload, 32'h0);
    chk("rst iREN", {31'h0, iREN}, 32'h0);
    chk("rst iaddr", iaddr, 32'h0);
    next_cycle();
    nRST = 1'b1;
    next_cycle();

    // Cold miss then hit
    do_fill("cold", 32'h0000_0040, 32'h2108_000A);
    next_cycle();

    // Wait states: iwait high for 3 fill cycles
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0088;
    iwait    = 1'b1;
    iload    = 32'h1234_5678;
    #1;
    chk("wait c0 ihit", {31'h0, ihit}, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      iwait = (c == 4) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("wait c%0d iREN", c), {31'h0, iREN}, 32'h1);
      chk($sformatf("wait c%0d iaddr", c), iaddr, 32'h0000_0088);
      chk($sformatf("wait c%0d ihit", c), {31'h0, ihit}, 32'h0);
    end
    next_cycle();
    #1;
    chk("wait c5 ihit", {31'h0, ihit}, 32'h1);
    chk("wait c5 imemload", imemload, 32'h1234_5678);
    chk("wait c5 iREN", {31'h0, iREN}, 32'h0);
    next_cycle();

    // Conflict eviction on index 1
    do_fill("conf a", 32'h0000_0004, 32'hAAAA_AAAA);
    next_cycle();
    do_fill("conf b", 32'h0000_0044, 32'hBBBB_BBBB);
    next_cycle();
    imemaddr = 32'h0000_0004;
    iload    = 32'hAAAA_AAAA;
    #1;
    chk("conf reread ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    #1;
    chk("conf reread iREN", {31'h0, iREN}, 32'h1);
    chk("conf reread iaddr", iaddr, 32'h0000_0004);
    next_cycle();
    #1;
    chk("conf refill ihit", {31'h0, ihit}, 32'h1);
    chk("conf refill imemload", imemload, 32'hAAAA_AAAA);
    next_cycle();

    // Address change mid-fill
    imemaddr = 32'h0000_0100;
    iwait    = 1'b1;
    iload    = 32'hCAFE_0100;
    #1;
    chk("chg c0 ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    imemaddr = 32'h0000_0200;
    #1;
    chk("chg c1 iaddr", iaddr, 32'h0000_0100);
    chk("chg c1 ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    iwait = 1'b0;
    #1;
    chk("chg c2 iaddr", iaddr, 32'h0000_0100);
    next_cycle();
    #1;
    chk("chg c3 ihit 0x200", {31'h0, ihit}, 32'h0);
    imemaddr = 32'h0000_0100;
    #1;
    chk("chg c3 ihit 0x100", {31'h0, ihit}, 32'h1);
    chk("chg c3 imemload", imemload, 32'hCAFE_0100);
    imemaddr = 32'h0000_0200;
    iload    = 32'h0BAD_0200;
    #1;
    chk("chg c3 ihit back", {31'h0, ihit}, 32'h0);
    next_cycle();
    #1;
    chk("chg c4 iaddr", iaddr, 32'h0000_0200);
    next_cycle();
    #1;
    chk("chg c5 ihit", {31'h0, ihit}, 32'h1);
    chk("chg c5 imemload", imemload, 32'h0BAD_0200);
    next_cycle();

    // Flush after a fill, then flush during a completing fill
    do_fill("flush pre", 32'h0000_0040, 32'h2108_000A);
    next_cycle();
    iflush = 1'b1;
    #1;
    chk("flush same-cycle ihit", {31'h0, ihit}, 32'h0);
    chk("flush same-cycle imemload", imemload, 32'h0);
    next_cycle();
    iflush = 1'b0;
    #1;
    chk("flush after iREN", {31'h0, iREN}, 32'h0);
    chk("flush after ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    iflush = 1'b1;
    iwait  = 1'b0;
    iload  = 32'hDEAD_BEEF;
    #1;
    chk("flush fill iREN", {31'h0, iREN}, 32'h1);
    chk("flush fill iaddr", iaddr, 32'h0000_0040);
    next_cycle();
    iflush  = 1'b0;
    imemREN = 1'b0;
    #1;
    chk("flush abort iREN", {31'h0, iREN}, 32'h0);
    imemREN = 1'b1;
    #1;
    chk("flush abort ihit", {31'h0, ihit}, 32'h0);
    iload = 32'h2108_000A;
    next_cycle();
    #1;
    chk("flush refill iREN", {31'h0, iREN}, 32'h1);
    next_cycle();
    #1;
    chk("flush refill ihit", {31'h0, ihit}, 32'h1);
    chk("flush refill imemload", imemload, 32'h2108_000A);
    next_cycle();

    // Reset mid-fill
    imemaddr = 32'h0000_000C;
    iwait    = 1'b1;
    next_cycle();
    #1;
    chk("rstfill iREN before", {31'h0, iREN}, 32'h1);
    nRST    = 1'b0;
    imemREN = 1'b0;
    #1;
    chk("rstfill iREN", {31'h0, iREN}, 32'h0);
    chk("rstfill iaddr", iaddr, 32'h0);
    next_cycle();
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    iwait    = 1'b0;
    #1;
    chk("rstfill reread ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    #1;
    chk("rstfill reread iREN", {31'h0, iREN}, 32'h1);
    chk("rstfill reread iaddr", iaddr, 32'h0000_0040);
    next_cycle();
    #1;
    chk("rstfill reread hit", {31'h0, ihit}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
